// File: rtl/systolic_pkg.sv
// Shared types and arithmetic helpers for the output-stationary systolic matmul engine.
// Words are held in 64-bit containers inside sat_add, so NBITS is limited to 32.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Zero-injection advances needed to push the last skewed operand into the far PE.
  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // The product is clamped on its own first, then the sum is clamped.
  // In wrap mode the result is sign-extended from bit nbits-1.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                 input logic signed [63:0] prod,
                                                 input int nbits,
                                                 input bit sat);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] p;
    logic signed [63:0] s;
    max_v = (64'sd1 <<< (nbits - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    p = prod;
    if (sat) begin
      if (p > max_v) p = max_v;
      else if (p < min_v) p = min_v;
    end
    s = acc + p;
    if (sat) begin
      if (s > max_v) s = max_v;
      else if (s < min_v) s = min_v;
    end else begin
      s = (s <<< (64 - nbits)) >>> (64 - nbits);
    end
    return s;
  endfunction

endpackage

// File: rtl/systolic_mm_engine_pe.sv
// One multiply-accumulate cell: registers x east and w south and accumulates on the same edge.
module systolic_mac_pe
  import systolic_pkg::*;
#(
  parameter int NBITS = 16,
  parameter int DBITS = 8,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [NBITS-1:0] x_in,
  input  logic [NBITS-1:0] w_in,
  output logic [NBITS-1:0] x_out,
  output logic [NBITS-1:0] w_out,
  output logic [NBITS-1:0] acc
);

  logic [NBITS-1:0] x_q, x_d;
  logic [NBITS-1:0] w_q, w_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic signed [2*NBITS-1:0] prod_full;
  logic signed [2*NBITS-1:0] prod_sh;

  always_comb begin
    prod_full = $signed(x_in) * $signed(w_in);
    // Arithmetic shift truncates toward minus infinity.
    prod_sh   = prod_full >>> DBITS;
    x_d   = x_q;
    w_d   = w_q;
    acc_d = acc_q;
    if (clr) begin
      x_d   = '0;
      w_d   = '0;
      acc_d = '0;
    end else if (en) begin
      x_d   = x_in;
      w_d   = w_in;
      acc_d = NBITS'(sat_add(64'($signed(acc_q)), 64'(prod_sh), NBITS, SAT != 0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      w_q   <= '0;
      acc_q <= '0;
    end else begin
      x_q   <= x_d;
      w_q   <= w_d;
      acc_q <= acc_d;
    end
  end

  assign x_out = x_q;
  assign w_out = w_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// Self-sequencing output-stationary systolic matmul: FEED skewed operands, FLUSH with zeros,
// then DRAIN one accumulator row per out handshake. Handshakes fire when valid && ready.
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int K_MAX = 16,
  parameter int NBITS = 16,
  parameter int DBITS = 8,
  parameter int SAT   = 1,
  localparam int KW   = $clog2(K_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KW-1:0]         cfg_k,
  output logic                  busy,
  output logic                  done,
  input  logic                  x_val,
  output logic                  x_rdy,
  input  logic [ROWS*NBITS-1:0] x_data,
  input  logic                  w_val,
  output logic                  w_rdy,
  input  logic [COLS*NBITS-1:0] w_data,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [COLS*NBITS-1:0] out_data,
  output logic                  out_last,
  output state_t                dbg_state
);

  localparam int FLUSH_LEN = flush_len(ROWS, COLS);
  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [RW-1:0] row_q, row_d;
  logic          done_q, done_d;
  logic [KW-1:0] k_eff;
  logic          fire, advance, clr_arr, row_is_last;

  assign fire        = (state_q == FEED) && x_val && w_val;
  assign advance     = fire || (state_q == FLUSH);
  assign clr_arr     = (state_q == IDLE) && start;
  assign row_is_last = (row_q == RW'(ROWS - 1));
  assign k_eff       = (cfg_k > KW'(K_MAX)) ? KW'(K_MAX) : cfg_k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_len_q <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = (k_eff == '0) ? DRAIN : FEED;
      FEED:  if (fire && (beat_q == k_len_q - KW'(1))) state_d = FLUSH;
      FLUSH: if (flush_q == FW'(FLUSH_LEN - 1)) state_d = DRAIN;
      DRAIN: if (out_rdy && row_is_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    k_len_d = k_len_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        k_len_d = k_eff;
        beat_d  = '0;
        flush_d = '0;
        row_d   = '0;
      end
      FEED:  if (fire) beat_d = beat_q + KW'(1);
      FLUSH: flush_d = flush_q + FW'(1);
      DRAIN: if (out_rdy) begin
        row_d  = row_is_last ? '0 : row_q + RW'(1);
        done_d = row_is_last;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    x_rdy     = (state_q == FEED) && w_val;
    w_rdy     = (state_q == FEED) && x_val;
    out_val   = (state_q == DRAIN);
    out_last  = (state_q == DRAIN) && row_is_last;
    done      = done_q;
    dbg_state = state_q;
  end

  // Lanes carry live data only in FEED; FLUSH advances inject zeros.
  logic [NBITS-1:0] x_inj  [ROWS];
  logic [NBITS-1:0] w_inj  [COLS];
  logic [NBITS-1:0] x_edge [ROWS];
  logic [NBITS-1:0] w_edge [COLS];

  always_comb begin
    for (int r = 0; r < ROWS; r++) x_inj[r] = (state_q == FEED) ? x_data[r*NBITS +: NBITS] : '0;
    for (int c = 0; c < COLS; c++) w_inj[c] = (state_q == FEED) ? w_data[c*NBITS +: NBITS] : '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_xskew
    if (r == 0) begin : g_direct
      assign x_edge[r] = x_inj[r];
    end else begin : g_regs
      logic [NBITS-1:0] sk_q [r];
      logic [NBITS-1:0] sk_d [r];
      always_comb begin
        for (int j = 0; j < r; j++) sk_d[j] = sk_q[j];
        if (clr_arr) begin
          for (int j = 0; j < r; j++) sk_d[j] = '0;
        end else if (advance) begin
          sk_d[0] = x_inj[r];
          for (int j = 1; j < r; j++) sk_d[j] = sk_q[j-1];
        end
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) for (int j = 0; j < r; j++) sk_q[j] <= '0;
        else     for (int j = 0; j < r; j++) sk_q[j] <= sk_d[j];
      end
      assign x_edge[r] = sk_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_wskew
    if (c == 0) begin : g_direct
      assign w_edge[c] = w_inj[c];
    end else begin : g_regs
      logic [NBITS-1:0] sk_q [c];
      logic [NBITS-1:0] sk_d [c];
      always_comb begin
        for (int j = 0; j < c; j++) sk_d[j] = sk_q[j];
        if (clr_arr) begin
          for (int j = 0; j < c; j++) sk_d[j] = '0;
        end else if (advance) begin
          sk_d[0] = w_inj[c];
          for (int j = 1; j < c; j++) sk_d[j] = sk_q[j-1];
        end
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) for (int j = 0; j < c; j++) sk_q[j] <= '0;
        else     for (int j = 0; j < c; j++) sk_q[j] <= sk_d[j];
      end
      assign w_edge[c] = sk_q[c-1];
    end
  end

  logic [NBITS-1:0] x_link  [ROWS][COLS+1];
  logic [NBITS-1:0] w_link  [ROWS+1][COLS];
  logic [NBITS-1:0] acc_arr [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_xin
    assign x_link[r][0] = x_edge[r];
  end
  for (genvar c = 0; c < COLS; c++) begin : g_win
    assign w_link[0][c] = w_edge[c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      systolic_mac_pe #(.NBITS(NBITS), .DBITS(DBITS), .SAT(SAT)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .en    (advance),
        .clr   (clr_arr),
        .x_in  (x_link[r][c]),
        .w_in  (w_link[r][c]),
        .x_out (x_link[r][c+1]),
        .w_out (w_link[r+1][c]),
        .acc   (acc_arr[r][c])
      );
    end
  end

  // row_q only moves on an out handshake, so out_data holds while stalled.
  always_comb begin
    out_data = '0;
    for (int c = 0; c < COLS; c++) out_data[c*NBITS +: NBITS] = acc_arr[row_q][c];
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench: 4x4 saturating engine (identity, stalls, saturation, K=0, clamp, abort)
// plus a 2x3 wrapping engine (non-square and wrap-around).
module tb_systolic_mm_engine;
  import systolic_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [63:0] exp_q[$];

  // 4x4, SAT=1
  logic        a_rst, a_start, a_x_val, a_w_val, a_out_rdy;
  logic [4:0]  a_cfg_k;
  logic [63:0] a_x_data, a_w_data, a_out_data;
  logic        a_busy, a_done, a_x_rdy, a_w_rdy, a_out_val, a_out_last;
  state_t      a_state;

  // 2x3, SAT=0
  logic        b_rst, b_start, b_x_val, b_w_val, b_out_rdy;
  logic [4:0]  b_cfg_k;
  logic [31:0] b_x_data;
  logic [47:0] b_w_data, b_out_data;
  logic        b_busy, b_done, b_x_rdy, b_w_rdy, b_out_val, b_out_last;
  state_t      b_state;

  logic [63:0] xa [19];
  logic [63:0] wa [19];

  systolic_mm_engine #(.ROWS(4), .COLS(4), .K_MAX(16), .NBITS(16), .DBITS(8), .SAT(1)) u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .cfg_k(a_cfg_k), .busy(a_busy), .done(a_done),
    .x_val(a_x_val), .x_rdy(a_x_rdy), .x_data(a_x_data),
    .w_val(a_w_val), .w_rdy(a_w_rdy), .w_data(a_w_data),
    .out_val(a_out_val), .out_rdy(a_out_rdy), .out_data(a_out_data), .out_last(a_out_last),
    .dbg_state(a_state)
  );

  systolic_mm_engine #(.ROWS(2), .COLS(3), .K_MAX(16), .NBITS(16), .DBITS(8), .SAT(0)) u_b (
    .clk(clk), .rst(b_rst), .start(b_start), .cfg_k(b_cfg_k), .busy(b_busy), .done(b_done),
    .x_val(b_x_val), .x_rdy(b_x_rdy), .x_data(b_x_data),
    .w_val(b_w_val), .w_rdy(b_w_rdy), .w_data(b_w_data),
    .out_val(b_out_val), .out_rdy(b_out_rdy), .out_data(b_out_data), .out_last(b_out_last),
    .dbg_state(b_state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start_a(input int k);
    @(negedge clk);
    a_start = 1'b1;
    a_cfg_k = 5'(k);
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic feed_a(input int n, input bit gaps, output int used);
    int cyc;
    bit fired;
    cyc  = 0;
    used = 0;
    while (used < n && a_state == FEED && cyc < 300) begin
      a_x_data = xa[used];
      a_w_data = wa[used];
      a_x_val  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      a_w_val  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      fired = a_x_val && a_x_rdy && a_w_val && a_w_rdy;
      @(negedge clk);
      if (fired) used++;
      cyc++;
    end
    a_x_val = 1'b0;
    a_w_val = 1'b0;
    if (cyc >= 300) chk("feed_timeout", 64'(cyc), 64'd0);
  endtask

  task automatic collect_a(input int stall_at);
    int cyc;
    logic [63:0] e;
    cyc = 0;
    while (!a_out_val && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_wait", 64'(a_out_val), 64'd1);
    for (int r = 0; r < 4; r++) begin
      e = exp_q.pop_front();
      if (r == stall_at) begin
        a_out_rdy = 1'b0;
        repeat (3) begin
          a_start = 1'b1;
          a_cfg_k = 5'd2;
          chk("hold_data", a_out_data, e);
          @(negedge clk);
        end
        a_start = 1'b0;
      end
      a_out_rdy = 1'b1;
      chk($sformatf("row%0d_val", r), 64'(a_out_val), 64'd1);
      chk($sformatf("row%0d_data", r), a_out_data, e);
      chk($sformatf("row%0d_last", r), 64'(a_out_last), 64'(r == 3));
      chk("done_early", 64'(a_done), 64'd0);
      @(negedge clk);
    end
    a_out_rdy = 1'b0;
    chk("done_pulse", 64'(a_done), 64'd1);
    @(negedge clk);
    chk("done_clear", 64'(a_done), 64'd0);
    chk("busy_idle", 64'(a_busy), 64'd0);
  endtask

  task automatic run_b(input int k, input logic [15:0] xv, input logic [15:0] wv,
                       input logic [15:0] ev, input string tag);
    int cyc;
    int used;
    @(negedge clk);
    b_start = 1'b1;
    b_cfg_k = 5'(k);
    @(negedge clk);
    b_start  = 1'b0;
    b_x_data = {2{xv}};
    b_w_data = {3{wv}};
    b_x_val  = 1'b1;
    b_w_val  = 1'b1;
    cyc  = 0;
    used = 0;
    while (b_state == FEED && cyc < 100) begin
      #1;
      if (b_x_rdy && b_w_rdy) used++;
      @(negedge clk);
      cyc++;
    end
    b_x_val = 1'b0;
    b_w_val = 1'b0;
    chk({tag, "_beats"}, 64'(used), 64'(k));
    cyc = 0;
    while (!b_out_val && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    for (int r = 0; r < 2; r++) begin
      b_out_rdy = 1'b1;
      chk($sformatf("%s_row%0d", tag, r), 64'(b_out_data), 64'({3{ev}}));
      chk($sformatf("%s_last%0d", tag, r), 64'(b_out_last), 64'(r == 1));
      @(negedge clk);
    end
    b_out_rdy = 1'b0;
    chk({tag, "_done"}, 64'(b_done), 64'd1);
  endtask

  task automatic load_identity();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        xa[k][i*16 +: 16] = (i == k) ? 16'h0100 : 16'h0000;
        wa[k][i*16 +: 16] = 16'(16'h0100 * (4 * k + i + 1));
      end
    end
  endtask

  task automatic push_identity_rows();
    logic [63:0] row;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) row[c*16 +: 16] = 16'(16'h0100 * (4 * r + c + 1));
      exp_q.push_back(row);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int used;
    bit seen_done;
    a_rst = 1'b1; a_start = 1'b0; a_cfg_k = '0; a_x_val = 1'b0; a_w_val = 1'b0;
    a_out_rdy = 1'b0; a_x_data = '0; a_w_data = '0;
    b_rst = 1'b1; b_start = 1'b0; b_cfg_k = '0; b_x_val = 1'b0; b_w_val = 1'b0;
    b_out_rdy = 1'b0; b_x_data = '0; b_w_data = '0;
    repeat (3) @(negedge clk);
    a_x_val = 1'b1;
    a_w_val = 1'b1;
    #1;
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_out_val", 64'(a_out_val), 64'd0);
    chk("rst_out_last", 64'(a_out_last), 64'd0);
    chk("rst_x_rdy", 64'(a_x_rdy), 64'd0);
    chk("rst_w_rdy", 64'(a_w_rdy), 64'd0);
    chk("rst_b_busy", 64'(b_busy), 64'd0);
    a_x_val = 1'b0;
    a_w_val = 1'b0;
    @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Identity: output rows reproduce W rows
    load_identity();
    push_identity_rows();
    start_a(4);
    feed_a(4, 1'b0, used);
    chk("id_beats", 64'(used), 64'd4);
    collect_a(-1);

    // Same job with random input gaps and a 3-cycle out stall on row 1
    push_identity_rows();
    start_a(4);
    feed_a(4, 1'b1, used);
    chk("stall_beats", 64'(used), 64'd4);
    collect_a(1);

    // Saturation: 127.0 * 2.0 overflows immediately
    for (int k = 0; k < 2; k++) begin
      xa[k] = {4{16'h7F00}};
      wa[k] = {4{16'h0200}};
    end
    for (int r = 0; r < 4; r++) exp_q.push_back({4{16'h7FFF}});
    start_a(2);
    feed_a(2, 1'b0, used);
    chk("sat_beats", 64'(used), 64'd2);
    collect_a(-1);

    // K=0: straight to DRAIN, zero rows, operands never accepted
    start_a(0);
    a_x_val = 1'b1;
    a_w_val = 1'b1;
    #1;
    chk("k0_x_rdy", 64'(a_x_rdy), 64'd0);
    chk("k0_w_rdy", 64'(a_w_rdy), 64'd0);
    a_x_val = 1'b0;
    a_w_val = 1'b0;
    for (int r = 0; r < 4; r++) exp_q.push_back(64'd0);
    collect_a(-1);

    // Clamp: cfg_k=19 consumes exactly 16 beats of 0.0625*1.0 -> 1.0
    for (int k = 0; k < 19; k++) begin
      xa[k] = {4{16'h0010}};
      wa[k] = {4{16'h0100}};
    end
    for (int r = 0; r < 4; r++) exp_q.push_back({4{16'h0100}});
    start_a(19);
    feed_a(19, 1'b0, used);
    chk("clamp_beats", 64'(used), 64'd16);
    collect_a(-1);

    // Abort after 2 beats, then a clean identity job
    load_identity();
    start_a(4);
    feed_a(2, 1'b0, used);
    chk("abort_beats", 64'(used), 64'd2);
    a_rst = 1'b1;
    #1;
    chk("abort_busy", 64'(a_busy), 64'd0);
    chk("abort_out_val", 64'(a_out_val), 64'd0);
    chk("abort_state", 64'(a_state), 64'(IDLE));
    @(negedge clk);
    a_rst = 1'b0;
    seen_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_done = seen_done | a_done;
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);
    push_identity_rows();
    start_a(4);
    feed_a(4, 1'b0, used);
    chk("post_abort_beats", 64'(used), 64'd4);
    collect_a(-1);

    // 2x3 wrapping engine: 5 * (0.5*2.0) = 5.0; 2 * 254.0 wraps to 0xFC00
    run_b(5, 16'h0080, 16'h0200, 16'h0500, "nonsq");
    run_b(2, 16'h7F00, 16'h0200, 16'hFC00, "wrap");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
